gcd_req_sched: RTL and testbench

Request scheduler that sits directly upstream and downstream of the GCD unit top (gcd_rtl_top).
- Accepts a stream of operand pairs through a val/rdy handshake and buffers them in a small FIFO.
- Issues exactly one pair at a time to the GCD unit through its input_available / result_rdy / result_taken interface.
- Returns each result, tagged with its operands, on a registered val/rdy response port.
- Guarantees the GCD unit only sees input_available while it is in its WAIT state.

---
 rtl/gcd_req_sched.sv | 183 ++++++++++++++++++
 tb/tb_gcd_req_sched.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_req_sched.sv
// Request scheduler wrapped around a GCD unit: buffers operand pairs in a FIFO,
// issues them one at a time, and returns each tagged result on a registered port.
module gcd_req_sched #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic         clk,
    input  logic         reset,
    // Upstream requests
    input  logic         req_val,
    output logic         req_rdy,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    // GCD unit interface
    output logic [W-1:0] gcd_operand_A,
    output logic [W-1:0] gcd_operand_B,
    output logic         gcd_input_available,
    input  logic [W-1:0] gcd_result_data,
    input  logic         gcd_result_rdy,
    output logic         gcd_result_taken,
    // Downstream responses
    output logic         resp_val,
    input  logic         resp_rdy,
    output logic [W-1:0] resp_data,
    output logic [W-1:0] resp_a,
    output logic [W-1:0] resp_b,
    // Status
    output logic         busy,
    output logic [1:0]   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where val && rdy are both
    // high; rdy never depends on val, and a held val keeps its payload stable.

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RES = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    state_t state_q, state_d;

    logic [2*W-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;

    logic [W-1:0] opa_q, opa_d;
    logic [W-1:0] opb_q, opb_d;
    logic         ia_q, ia_d;

    logic         resp_val_q, resp_val_d;
    logic [W-1:0] resp_data_q, resp_data_d;
    logic [W-1:0] resp_a_q, resp_a_d;
    logic [W-1:0] resp_b_q, resp_b_d;

    logic push;
    logic pop;
    logic take;
    logic slot_free;
    logic fifo_empty;

    assign fifo_empty = (count_q == '0);
    assign req_rdy    = (count_q != FULL_CNT);
    assign push       = req_val && req_rdy;
    // The slot can be refilled in the same cycle it drains.
    assign slot_free  = !resp_val_q || resp_rdy;

    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        ia_d        = 1'b0;
        pop         = 1'b0;
        take        = 1'b0;
        resp_val_d  = resp_val_q;
        resp_data_d = resp_data_q;
        resp_a_d    = resp_a_q;
        resp_b_d    = resp_b_q;

        if (resp_val_q && resp_rdy) begin
            resp_val_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    opa_d   = mem_q[rd_ptr_q][2*W-1:W];
                    opb_d   = mem_q[rd_ptr_q][W-1:0];
                    ia_d    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                // A full slot leaves the GCD unit parked in DONE.
                if (gcd_result_rdy && slot_free) begin
                    take        = 1'b1;
                    resp_val_d  = 1'b1;
                    resp_data_d = gcd_result_data;
                    resp_a_d    = opa_q;
                    resp_b_d    = opb_q;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            ia_q        <= 1'b0;
            resp_val_q  <= 1'b0;
            resp_data_q <= '0;
            resp_a_q    <= '0;
            resp_b_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            ia_q        <= ia_d;
            resp_val_q  <= resp_val_d;
            resp_data_q <= resp_data_d;
            resp_a_q    <= resp_a_d;
            resp_b_q    <= resp_b_d;
        end
    end

    // Storage is only read after being written, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= {req_a, req_b};
        end
    end

    assign gcd_operand_A       = opa_q;
    assign gcd_operand_B       = opb_q;
    assign gcd_input_available = ia_q;
    assign gcd_result_taken    = take;

    assign resp_val  = resp_val_q;
    assign resp_data = resp_data_q;
    assign resp_a    = resp_a_q;
    assign resp_b    = resp_b_q;

    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gcd_req_sched.sv
// Bench for gcd_req_sched: a behavioural GCD unit, a queue scoreboard fed by the
// request driver, and a response/protocol monitor sampling on the falling edge.
module tb_gcd_req_sched;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         req_val;
    logic         req_rdy;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [W-1:0] gcd_operand_A;
    logic [W-1:0] gcd_operand_B;
    logic         gcd_input_available;
    logic [W-1:0] gcd_result_data;
    logic         gcd_result_rdy;
    logic         gcd_result_taken;
    logic         resp_val;
    logic         resp_rdy;
    logic [W-1:0] resp_data;
    logic [W-1:0] resp_a;
    logic [W-1:0] resp_b;
    logic         busy;
    logic [1:0]   dbg_state;

    logic man_rdy;
    logic rnd_rdy;
    logic rand_rdy_en;
    assign resp_rdy = rand_rdy_en ? rnd_rdy : man_rdy;

    int checks;
    int failures;

    logic [3*W-1:0] exp_q[$];
    logic [W-1:0]   got_q[$];

    int ia_cnt;
    int tk_cnt;
    logic ia_prev;
    logic x_en;
    logic hold_v;
    logic [3*W-1:0] hold_val;
    logic [3*W-1:0] last_resp;

    typedef enum logic [1:0] {G_WAIT, G_CALC, G_DONE} g_state_t;
    g_state_t     g_st;
    int           g_cnt;
    logic [W-1:0] g_res;
    int           lat_min;
    int           lat_max;

    gcd_req_sched #(.W(W), .DEPTH(4), .AW(2)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_val             (req_val),
        .req_rdy             (req_rdy),
        .req_a               (req_a),
        .req_b               (req_b),
        .gcd_operand_A       (gcd_operand_A),
        .gcd_operand_B       (gcd_operand_B),
        .gcd_input_available (gcd_input_available),
        .gcd_result_data     (gcd_result_data),
        .gcd_result_rdy      (gcd_result_rdy),
        .gcd_result_taken    (gcd_result_taken),
        .resp_val            (resp_val),
        .resp_rdy            (resp_rdy),
        .resp_data           (resp_data),
        .resp_a              (resp_a),
        .resp_b              (resp_b),
        .busy                (busy),
        .dbg_state           (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference arithmetic ----------------
    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural GCD unit ----------------
    always @(posedge clk) begin
        if (reset) begin
            g_st            <= G_WAIT;
            g_cnt           <= 0;
            g_res           <= '0;
            gcd_result_rdy  <= 1'b0;
            gcd_result_data <= '0;
        end else begin
            case (g_st)
                G_WAIT: if (gcd_input_available) begin
                    g_res <= ref_gcd(gcd_operand_A, gcd_operand_B);
                    g_cnt <= int'($urandom_range(lat_max, lat_min));
                    g_st  <= G_CALC;
                end
                G_CALC: if (g_cnt <= 1) begin
                    g_st            <= G_DONE;
                    gcd_result_rdy  <= 1'b1;
                    gcd_result_data <= g_res;
                end else begin
                    g_cnt <= g_cnt - 1;
                end
                G_DONE: if (gcd_result_taken) begin
                    gcd_result_rdy <= 1'b0;
                    g_st           <= G_WAIT;
                end
                default: g_st <= G_WAIT;
            endcase
        end
    end

    // ---------------- random downstream ready ----------------
    initial begin
        rnd_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- response monitor / scoreboard ----------------
    initial begin
        logic [3*W-1:0] e;
        hold_v = 1'b0;
        hold_val = '0;
        last_resp = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check("resp_hold_val", resp_val, 1);
                    check("resp_hold_payload", {resp_data, resp_a, resp_b}, hold_val);
                end
                if (resp_val && resp_rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL resp_unexpected actual=%0d expected=none", resp_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_data", resp_data, e[3*W-1:2*W]);
                        check("resp_a", resp_a, e[2*W-1:W]);
                        check("resp_b", resp_b, e[W-1:0]);
                    end
                    got_q.push_back(resp_data);
                    last_resp = {resp_data, resp_a, resp_b};
                end
                hold_v   = resp_val && !resp_rdy;
                hold_val = {resp_data, resp_a, resp_b};
            end
        end
    end

    // ---------------- GCD-side protocol monitor ----------------
    initial begin
        ia_prev = 1'b0;
        ia_cnt = 0;
        tk_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ia_prev = 1'b0;
            end else begin
                if (x_en) begin
                    check("no_x_on_gcd_outputs",
                          64'($isunknown({gcd_operand_A, gcd_operand_B, gcd_input_available, gcd_result_taken})), 0);
                end
                if (gcd_input_available) begin
                    ia_cnt++;
                    check("ia_not_back_to_back", ia_prev, 0);
                    check("ia_only_in_gcd_wait", (g_st == G_WAIT), 1);
                end
                if (gcd_result_taken) begin
                    tk_cnt++;
                    check("taken_only_when_result_rdy", gcd_result_rdy, 1);
                end
                ia_prev = gcd_input_available;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b, output int waits);
        bit done;
        done = 0;
        waits = 0;
        req_val = 1'b1;
        req_a = a;
        req_b = b;
        while (!done) begin
            @(negedge clk);
            if (req_rdy && !reset) begin
                exp_q.push_back({ref_gcd(a, b), a, b});
                done = 1;
            end else if (waits >= 300) begin
                checks++;
                failures++;
                $display("FAIL req_accept_timeout actual=%0d expected=<300", waits);
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        req_val = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (n < 1000 && !(exp_q.size() == 0 && !busy && !resp_val)) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_in_time"}, (n < 1000), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int w;
        int n;
        int g;
        int t0;
        int k0;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_seq [5];

        checks = 0;
        failures = 0;
        x_en = 1'b0;
        reset = 1'b1;
        req_val = 1'b0;
        req_a = '0;
        req_b = '0;
        man_rdy = 1'b1;
        rand_rdy_en = 1'b0;
        lat_min = 1;
        lat_max = 4;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_rdy", req_rdy, 1);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        check("rst_resp_val", resp_val, 0);
        check("rst_ia", gcd_input_available, 0);
        check("rst_taken", gcd_result_taken, 0);
        check("rst_operands", {gcd_operand_A, gcd_operand_B}, 0);
        check("rst_resp_payload", {resp_data, resp_a, resp_b}, 0);
        reset = 1'b0;
        x_en = 1'b1;

        // Single request with issue latency
        t0 = ia_cnt;
        k0 = tk_cnt;
        drive_req(16'd27, 16'd15, w);
        @(posedge clk);
        #1;
        check("t1_ia_two_cycles_after_push", gcd_input_available, 1);
        check("t1_operand_A", gcd_operand_A, 27);
        check("t1_operand_B", gcd_operand_B, 15);
        wait_drain("t1");
        check("t1_resp", last_resp, {16'd3, 16'd27, 16'd15});
        check("t1_one_issue", ia_cnt - t0, 1);
        check("t1_one_take", tk_cnt - k0, 1);
        check("t1_busy_low", busy, 0);

        // Burst with zero operands
        lat_max = 6;
        got_q.delete();
        drive_req(16'd12, 16'd18, w);
        drive_req(16'd7, 16'd5, w);
        drive_req(16'd0, 16'd9, w);
        drive_req(16'd9, 16'd0, w);
        drive_req(16'd0, 16'd0, w);
        wait_drain("t2");
        exp_seq = '{16'd6, 16'd1, 16'd9, 16'd9, 16'd0};
        check("t2_resp_count", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            check("t2_resp_order", got_q[i], exp_seq[i]);
        end

        // Backpressure: first result parks in the slot, second parks in the GCD unit
        lat_max = 3;
        man_rdy = 1'b0;
        drive_req(16'd48, 16'd36, w);
        drive_req(16'd100, 16'd75, w);
        n = 0;
        while (n < 200 && !(g_st == G_DONE && resp_val)) begin
            @(negedge clk);
            n++;
        end
        check("t3_reached_double_hold", (n < 200), 1);
        repeat (3) begin
            @(negedge clk);
            check("t3_held_resp", {resp_val, resp_data, resp_a, resp_b}, {1'b1, 16'd12, 16'd48, 16'd36});
            check("t3_no_take", gcd_result_taken, 0);
            check("t3_state_wait", dbg_state, 2);
        end
        @(posedge clk);
        #1;
        man_rdy = 1'b1;
        @(posedge clk);
        #1;
        man_rdy = 1'b0;
        check("t3_refill_same_edge", {resp_val, resp_data, resp_a, resp_b}, {1'b1, 16'd25, 16'd100, 16'd75});
        man_rdy = 1'b1;
        wait_drain("t3");

        // Fill the FIFO behind a blocked response, then drain through the wrap
        lat_min = 1;
        lat_max = 2;
        man_rdy = 1'b0;
        drive_req(16'd20, 16'd8, w);
        drive_req(16'd35, 16'd14, w);
        repeat (30) @(posedge clk);
        #1;
        drive_req(16'd81, 16'd27, w);
        check("t4_push3_immediate", w, 0);
        drive_req(16'd64, 16'd48, w);
        check("t4_push4_immediate", w, 0);
        drive_req(16'd13, 16'd13, w);
        check("t4_push5_immediate", w, 0);
        drive_req(16'd1, 16'hFFFF, w);
        check("t4_push6_immediate", w, 0);
        req_val = 1'b1;
        req_a = 16'd30;
        req_b = 16'd45;
        @(negedge clk);
        check("t4_full_req_rdy", req_rdy, 0);
        check("t4_full_busy", busy, 1);
        @(posedge clk);
        #1;
        man_rdy = 1'b1;
        drive_req(16'd30, 16'd45, w);
        check("t4_push7_stalled", (w > 0), 1);
        wait_drain("t4");

        // Reset while waiting for a result
        lat_min = 12;
        lat_max = 12;
        drive_req(16'd1071, 16'd462, w);
        n = 0;
        while (n < 100 && dbg_state != 2'd2) begin
            @(negedge clk);
            n++;
        end
        check("t5_reached_wait_res", (n < 100), 1);
        k0 = tk_cnt;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("t5_no_take_before_reset", gcd_result_taken, 0);
        @(posedge clk);
        #1;
        check("t5_req_rdy", req_rdy, 1);
        check("t5_busy", busy, 0);
        check("t5_state_idle", dbg_state, 0);
        check("t5_resp_val", resp_val, 0);
        check("t5_taken", gcd_result_taken, 0);
        reset = 1'b0;
        check("t5_no_take_pulse", tk_cnt - k0, 0);
        lat_min = 1;
        lat_max = 4;
        drive_req(16'd1071, 16'd462, w);
        wait_drain("t5");
        check("t5_resp_after_reset", last_resp, {16'd21, 16'd1071, 16'd462});

        // Randomised traffic with random downstream backpressure
        rand_rdy_en = 1'b1;
        lat_min = 1;
        lat_max = 5;
        for (int i = 0; i < 60; i++) begin
            g = int'($urandom_range(1, 40));
            a = W'(g * int'($urandom_range(0, 400)));
            b = W'(g * int'($urandom_range(0, 400)));
            if ($urandom_range(0, 9) == 0) a = '0;
            drive_req(a, b, w);
            n = int'($urandom_range(0, 3));
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy_en = 1'b0;
        man_rdy = 1'b1;
        wait_drain("t6");
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
